sys_utc_source: RTL
===================

# sys_utc_source

Transmit-side UTC time source: generates a one-cycle PPS strobe every `CLK_FREQ` cycles and, `UTC_DELAY` cycles after each PPS, a one-cycle UTC time message labelling the second that PPS started. It drives the `rx_pps_valid` / `rx_utc_time_*` inputs of `sys_utc_timer`, either as a GPS-receiver emulator in simulation and loopback tests, or as the local master time source when no GPS is fitted. Full calendar rollover covers second through year, with leap years.

## Interface
- `CLK_FREQ`, 100_000_000: clk cycles per second; must be ≥ 4.
- `UTC_DELAY`, 1000: cycles from PPS strobe to message strobe; 1 ≤ `UTC_DELAY` ≤ `CLK_FREQ`-2.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high = time runs and strobes are emitted.
- `load_valid`  in  1  one-cycle strobe; loads `load_*` as the current time.
- `load_second` / `load_minute`  in  6 each; `load_hour` / `load_day`  in  5 each; `load_month`  in  4; `load_year`  in  8 (years since 2000).
- `time_set`  out  1  set on first `load_valid`, cleared only by reset.
- `tx_pps_valid`  out  1  one-cycle PPS strobe.
- `tx_utc_time_valid`  out  1  one-cycle message strobe.
- `tx_utc_time_second`, `_minute`, `_hour`, `_day`, `_month`, `_year`  out  6/6/5/5/4/8  message fields; widths match the `sys_utc_timer` inputs.

## Operation
- Internal state: current time register (T), cycle counter `cnt` (0..`CLK_FREQ`-1), flag `pps_seen`.
- While `enable`=1 and no load, `cnt` increments each cycle.
- `cnt` = `CLK_FREQ`-1 → next edge: `cnt`←0, T←inc(T), `tx_pps_valid`=1 for one cycle, `pps_seen`←1.
- `cnt` = `UTC_DELAY`-1 with `pps_seen`=1 → next edge: `tx_utc_time_valid`=1 for one cycle, `tx_utc_time_*`←T. Fields hold until the next message.
- The message always labels the most recent PPS. A `sys_utc_timer` receiver predicting last+1 at the next PPS therefore stays consistent.
- `load_valid`: T←`load_*`, `cnt`←0, `pps_seen`←0, `time_set`←1. Loading works regardless of `enable`. The first PPS after the load comes `CLK_FREQ` cycles later and carries inc(load).
- `enable`=0: `cnt`←0, `pps_seen`←0, no strobes. T and the fields are retained.
- Calendar increment inc():
  - second ≥ 59 → 0 with carry.
  - minute ≥ 59 → 0 with carry.
  - hour ≥ 23 → 0 with carry.
  - day ≥ dim(month, year) → 1 with carry.
  - month ≥ 12 → 1 with carry.
  - year 255 → 0 (8-bit wrap).
  - The ≥ comparisons make out-of-range loads normalise on the next increment.
- dim(): Feb = 29 if year[1:0]=0, else 28. Apr, Jun, Sep, Nov = 30. All others = 31. Month 0 or >12 → 31.
- Simultaneous events:
  - `load_valid` in the wrap cycle → load wins; no PPS, T = loaded value.
  - `load_valid` in the message cycle → load wins; no message.
  - `enable` falling in the wrap cycle → no PPS.

## Timing
- Reset values: all outputs 0; T = 00:00:00, day 1, month 1, year 0; `cnt`=0; `pps_seen`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `enable` rising at edge E → first `tx_pps_valid` at edge E+`CLK_FREQ`.
- PPS period: exactly `CLK_FREQ` cycles.
- Message strobe: exactly `UTC_DELAY` cycles after each PPS strobe.
- `time_set` rises one edge after `load_valid`.

## Structure
- Package `sys_utc_pkg` holds:
  - field width localparams (SEC_W=6, MIN_W=6, HOUR_W=5, DAY_W=5, MON_W=4, YEAR_W=8);
  - packed struct `utc_time_t`;
  - function `days_in_month(month, year)`.
- `sys_utc_timer` adopts the same package.
- Sub-module `sys_utc_calendar_inc`: purely combinational `utc_time_t` → inc(`utc_time_t`). It is reusable by the receiver's prediction path.
- Top level: counter and strobe logic only.
- `cnt` width: `$clog2(CLK_FREQ)`.

## Test plan
All scenarios use `CLK_FREQ`=10, `UTC_DELAY`=3.
- Reset then release → all outputs 0. With `enable`=0 for 50 cycles → no strobes.
- Load 2025-12-31 23:59:59, then `enable` → PPS at +10. Message at +13 with 2026-01-01 00:00:00. Next message reads 00:00:01.
- Leap years: load 2024-02-28 23:59:59 → message 2024-02-29 00:00:00. Load 2025-02-28 23:59:59 → 2025-03-01. Load year 255 Dec 31 23:59:59 → year 0, Jan 1.
- Load second=63 → message second 0, minute+1. Load asserted exactly in the `cnt`=9 cycle → no PPS that cycle, next PPS 10 cycles later.
- Drop `enable` at `cnt`=5 for 7 cycles → no strobes during the gap. After re-enable, PPS exactly 10 cycles later, with T unchanged plus one second.
- Loop back into `sys_utc_timer` (ENABLE_PRED=1): its `time_sync_done` asserts after the first message, its `pps_out` lags our PPS by 2 cycles, and its `utc_time_*` equals our message value +1 s at each PPS.

Source files
------------

// File: rtl/sys_utc_pkg.sv
// rtl/sys_utc_pkg.sv - shared UTC field widths, time struct and month-length helper
package sys_utc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 8;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [MON_W-1:0]  month;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } utc_time_t;

    localparam utc_time_t UTC_EPOCH = '{
        year:   '0,
        month:  MON_W'(1),
        day:    DAY_W'(1),
        hour:   '0,
        minute: '0,
        second: '0
    };

    // Year counts from 2000, so year[1:0]==0 is a leap year through 2099.
    function automatic logic [DAY_W-1:0] days_in_month(
        input logic [MON_W-1:0]  month,
        input logic [YEAR_W-1:0] year
    );
        logic [DAY_W-1:0] dim;
        case (month)
            MON_W'(2):  dim = (year[1:0] == 2'b00) ? DAY_W'(29) : DAY_W'(28);
            MON_W'(4),
            MON_W'(6),
            MON_W'(9),
            MON_W'(11): dim = DAY_W'(30);
            default:    dim = DAY_W'(31);
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/sys_utc_calendar_inc.sv
// rtl/sys_utc_calendar_inc.sv - combinational one-second calendar increment
module sys_utc_calendar_inc
    import sys_utc_pkg::*;
(
    input  utc_time_t cur,
    output utc_time_t nxt
);

    logic [DAY_W-1:0] dim;

    assign dim = days_in_month(cur.month, cur.year);

    // Limits use >= so out-of-range loaded fields normalise on the next tick.
    always_comb begin
        nxt = cur;
        if (cur.second < SEC_W'(59)) begin
            nxt.second = cur.second + SEC_W'(1);
        end else begin
            nxt.second = '0;
            if (cur.minute < MIN_W'(59)) begin
                nxt.minute = cur.minute + MIN_W'(1);
            end else begin
                nxt.minute = '0;
                if (cur.hour < HOUR_W'(23)) begin
                    nxt.hour = cur.hour + HOUR_W'(1);
                end else begin
                    nxt.hour = '0;
                    if (cur.day < dim) begin
                        nxt.day = cur.day + DAY_W'(1);
                    end else begin
                        nxt.day = DAY_W'(1);
                        if (cur.month < MON_W'(12)) begin
                            nxt.month = cur.month + MON_W'(1);
                        end else begin
                            nxt.month = MON_W'(1);
                            nxt.year  = cur.year + YEAR_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sys_utc_source.sv
// rtl/sys_utc_source.sv - PPS strobe and delayed UTC time message generator
module sys_utc_source
    import sys_utc_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int UTC_DELAY = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load_valid,
    input  logic [SEC_W-1:0]  load_second,
    input  logic [MIN_W-1:0]  load_minute,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [DAY_W-1:0]  load_day,
    input  logic [MON_W-1:0]  load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic              time_set,
    output logic              tx_pps_valid,
    output logic              tx_utc_time_valid,
    output logic [SEC_W-1:0]  tx_utc_time_second,
    output logic [MIN_W-1:0]  tx_utc_time_minute,
    output logic [HOUR_W-1:0] tx_utc_time_hour,
    output logic [DAY_W-1:0]  tx_utc_time_day,
    output logic [MON_W-1:0]  tx_utc_time_month,
    output logic [YEAR_W-1:0] tx_utc_time_year
);

    localparam int               CNT_W    = $clog2(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] CNT_MSG  = CNT_W'(UTC_DELAY - 1);

    logic [CNT_W-1:0] cnt;
    logic             pps_seen;
    utc_time_t        cur_time;
    utc_time_t        next_time;
    utc_time_t        load_time;
    utc_time_t        msg_time;

    assign load_time = '{
        year:   load_year,
        month:  load_month,
        day:    load_day,
        hour:   load_hour,
        minute: load_minute,
        second: load_second
    };

    sys_utc_calendar_inc u_calendar_inc (
        .cur (cur_time),
        .nxt (next_time)
    );

    // Priority: load, then disable, then second wrap, then message slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= '0;
            pps_seen          <= 1'b0;
            cur_time          <= UTC_EPOCH;
            msg_time          <= '0;
            time_set          <= 1'b0;
            tx_pps_valid      <= 1'b0;
            tx_utc_time_valid <= 1'b0;
        end else begin
            tx_pps_valid      <= 1'b0;
            tx_utc_time_valid <= 1'b0;
            if (load_valid) begin
                cur_time <= load_time;
                cnt      <= '0;
                pps_seen <= 1'b0;
                time_set <= 1'b1;
            end else if (!enable) begin
                cnt      <= '0;
                pps_seen <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt          <= '0;
                cur_time     <= next_time;
                tx_pps_valid <= 1'b1;
                pps_seen     <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_MSG && pps_seen) begin
                    tx_utc_time_valid <= 1'b1;
                    msg_time          <= cur_time;
                end
            end
        end
    end

    assign tx_utc_time_second = msg_time.second;
    assign tx_utc_time_minute = msg_time.minute;
    assign tx_utc_time_hour   = msg_time.hour;
    assign tx_utc_time_day    = msg_time.day;
    assign tx_utc_time_month  = msg_time.month;
    assign tx_utc_time_year   = msg_time.year;

endmodule
